cosx_job_sequencer: RTL and testbench

//  Sits between the request source and the cosx_with_controller engine. It holds
//  (x, y) jobs in a FIFO and issues each one with a one-cycle Start pulse. It

---
 rtl/cosx_job_sequencer.sv | 159 +++++++++++++++
 tb/tb_cosx_job_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cosx_job_sequencer.sv
// Job sequencer in front of the cos(x) engine: queues (x, y) jobs, issues them one
// at a time with a Start pulse, and hands each finished Result out through a valid/ready slot.
module cosx_job_sequencer #(
    parameter int DEPTH = 4,
    parameter int XW    = 16,
    parameter int YW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XW-1:0]          in_x,
    input  logic [YW-1:0]          in_y,
    output logic                   eng_start,
    output logic [XW-1:0]          eng_x,
    output logic [YW-1:0]          eng_y,
    input  logic                   eng_ready,
    input  logic [XW-1:0]          eng_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XW-1:0]          out_result,
    output logic [XW-1:0]          out_x,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [1:0]             dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_LOW  = 2'd2,
        S_WAIT_HIGH = 2'd3
    } state_t;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are
    // both high; in_ready depends only on registered occupancy, never on out_ready.

    logic [XW-1:0] r_mem_x [DEPTH];
    logic [YW-1:0] r_mem_y [DEPTH];
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_rd_ptr;

    state_t        r_state;
    logic          r_eng_start;
    logic [XW-1:0] r_eng_x;
    logic [YW-1:0] r_eng_y;
    logic          r_out_valid;
    logic [XW-1:0] r_out_result;
    logic [XW-1:0] r_out_x;

    logic [LW-1:0] w_level;
    logic          w_full;
    logic          w_push;
    logic          w_slot_free;
    logic          w_pop;
    logic          w_capture;
    logic [XW-1:0] w_head_x;
    logic [YW-1:0] w_head_y;

    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_level == LW'(DEPTH));
    assign w_push      = in_valid && !w_full;
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_pop       = (r_state == S_IDLE) && (w_level != '0) && w_slot_free;
    assign w_capture   = (r_state == S_WAIT_HIGH) && eng_ready;
    assign w_head_x    = r_mem_x[r_rd_ptr[AW-1:0]];
    assign w_head_y    = r_mem_y[r_rd_ptr[AW-1:0]];

    // Storage carries no reset: an entry is only read after the pointers say it was written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr[AW-1:0]] <= in_x;
            r_mem_y[r_wr_ptr[AW-1:0]] <= in_y;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LW'(1);
            end
        end
    end

    // The Start pulse is registered on the ISSUE cycle, so it lands two edges after a push
    // into an idle sequencer. eng_x/eng_y are only reloaded on the next pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_eng_start <= 1'b0;
            r_eng_x     <= '0;
            r_eng_y     <= '0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_eng_x <= w_head_x;
                        r_eng_y <= w_head_y;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_eng_start <= 1'b1;
                    r_state     <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!eng_ready) begin
                        r_state <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (eng_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A capture wins over a simultaneous consumer accept: the slot stays full with the new job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_x      <= '0;
        end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_result <= eng_result;
            r_out_x      <= r_eng_x;
        end else if (r_out_valid && out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready   = !w_full;
    assign eng_start  = r_eng_start;
    assign eng_x      = r_eng_x;
    assign eng_y      = r_eng_y;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_x      = r_out_x;
    assign busy       = (r_state != S_IDLE);
    assign level      = w_level;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_cosx_job_sequencer.sv
// Bench for cosx_job_sequencer: a behavioural engine stand-in, an in-order scoreboard
// fed by the job driver, and monitors on the Start pulse and the output handshake.
module tb_cosx_job_sequencer;

    localparam int DEPTH = 4;
    localparam int XW    = 16;
    localparam int YW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic          eng_start;
    logic [XW-1:0] eng_x;
    logic [YW-1:0] eng_y;
    logic          eng_ready;
    logic [XW-1:0] eng_result;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] out_result;
    logic [XW-1:0] out_x;
    logic          busy;
    logic [2:0]    level;
    logic [1:0]    dbg_state;

    cosx_job_sequencer #(.DEPTH(DEPTH), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_ready(eng_ready), .eng_result(eng_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_x(out_x),
        .busy(busy), .level(level), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [XW+YW-1:0] iss_q[$];
    logic [2*XW-1:0]  exp_q[$];
    logic [XW-1:0]    out_log[$];
    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    bit prev_start = 0;

    // engine stand-in controls
    bit            eng_hold = 0;
    bit            eng_busy = 0;
    bit            eng_orphan = 0;
    int            eng_cnt = 0;
    int            eng_lat_lo = 0;
    int            eng_lat_hi = 5;
    logic [XW-1:0] eng_lat_x;

    function automatic logic [XW-1:0] cos_ref(input logic [XW-1:0] x);
        real a;
        int  r;
        a = $itor($signed(x)) / 256.0;
        r = $rtoi($cos(a) * 256.0);
        return r[XW-1:0];
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (eng_start) begin
                start_cnt++;
                check("start_single_cycle", {31'd0, prev_start}, 32'd0);
                if (iss_q.size() == 0) begin
                    check("unexpected_start", 32'd1, 32'd0);
                end else begin
                    logic [XW+YW-1:0] e;
                    e = iss_q.pop_front();
                    check("eng_x_at_start", {16'd0, eng_x}, {16'd0, e[XW+YW-1:YW]});
                    check("eng_y_at_start", {24'd0, eng_y}, {24'd0, e[YW-1:0]});
                end
            end
            prev_start = eng_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            out_log.push_back(out_result);
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                logic [2*XW-1:0] e;
                e = exp_q.pop_front();
                check("out_result", {16'd0, out_result}, {16'd0, e[2*XW-1:XW]});
                check("out_x", {16'd0, out_x}, {16'd0, e[XW-1:0]});
            end
        end
    end

    // ---------------- engine stand-in ----------------
    initial begin
        eng_ready  = 1'b1;
        eng_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (eng_busy) begin
                if (!eng_orphan) begin
                    check("eng_x_stable", {16'd0, eng_x}, {16'd0, eng_lat_x});
                    check("start_while_busy", {31'd0, eng_start}, 32'd0);
                end
                if (eng_cnt == 0) begin
                    eng_result = cos_ref(eng_lat_x);
                    eng_ready  = 1'b1;
                    eng_busy   = 0;
                end else begin
                    eng_cnt--;
                end
            end else if (rst && eng_start && !eng_hold) begin
                eng_lat_x  = eng_x;
                eng_ready  = 1'b0;
                eng_busy   = 1;
                eng_orphan = 0;
                eng_cnt    = $urandom_range(eng_lat_hi, eng_lat_lo);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive_cycle(input bit v, input logic [XW-1:0] x, input logic [YW-1:0] y,
                               output bit accepted);
        in_valid = v;
        in_x     = x;
        in_y     = y;
        @(negedge clk);
        accepted = v && in_ready;
        if (accepted) begin
            iss_q.push_back({x, y});
            exp_q.push_back({cos_ref(x), x});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [XW-1:0] x, input logic [YW-1:0] y);
        bit acc;
        drive_cycle(1'b1, x, y, acc);
        check("push_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        iss_q.delete();
        exp_q.delete();
        eng_orphan = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || out_valid || level != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, n >= 2000}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        check(name, {31'd0, out_valid}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int n0;
        int idx;
        int n;
        bit acc;
        logic [XW-1:0] held;

        rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_eng_start", {31'd0, eng_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_out_x", {16'd0, out_x}, 32'd0);
        check("rst_eng_x", {16'd0, eng_x}, 32'd0);
        check("rst_eng_y", {24'd0, eng_y}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_level", {29'd0, level}, 32'd0);
        @(posedge clk);
        #1;

        // single job, latency and known result
        n0 = start_cnt;
        idx = out_log.size();
        push(16'h009E, 8'h00);
        cyc = 0;
        while (!eng_start && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("start_latency", cyc, 32'd2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eng_ready && n < 50);
        check("out_valid_before_capture", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("out_valid_latency", {31'd0, out_valid}, 32'd1);
        wait_drain("drain_single");
        check("single_start_count", start_cnt - n0, 32'd1);
        if (out_log.size() > idx) check("single_result_const", {16'd0, out_log[idx]}, 32'h00D0);
        else check("single_result_missing", 32'd1, 32'd0);

        // two back-to-back jobs
        n0 = start_cnt;
        idx = out_log.size();
        push(16'h01E2, 8'h00);
        push(16'h009E, 8'h1E);
        wait_drain("drain_pair");
        check("pair_start_count", start_cnt - n0, 32'd2);
        if (out_log.size() > idx + 1) begin
            check("pair_first_const", {16'd0, out_log[idx]}, 32'hFFB2);
            check("pair_second_const", {16'd0, out_log[idx+1]}, 32'h00D0);
        end else check("pair_result_missing", 32'd1, 32'd0);

        // fill to full while the output slot is blocked
        out_ready = 1'b0;
        push(16'h0100, 8'h01);
        wait_out_valid("full_first_done");
        @(posedge clk);
        #1;
        eng_hold = 1;
        for (int i = 0; i < DEPTH; i++) begin
            push(16'h0010 * (i + 1), 8'(i));
            check("fill_level", {29'd0, level}, i + 1);
        end
        in_valid = 1'b1; in_x = 16'h0777; in_y = 8'h77;
        @(negedge clk);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_level", {29'd0, level}, DEPTH);
        drive_cycle(1'b1, 16'h0777, 8'h77, acc);
        check("full_push_rejected", {31'd0, acc}, 32'd0);
        check("full_level_after", {29'd0, level}, DEPTH);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("level_after_issue", {29'd0, level}, DEPTH - 1);
        check("busy_after_issue", {31'd0, busy}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        apply_reset();
        eng_hold = 0;
        @(negedge clk);
        check("flush_level", {29'd0, level}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // back-pressure holds the result and the next issue
        out_ready = 1'b0;
        push(16'hFF00, 8'h05);
        push(16'h0200, 8'h06);
        wait_out_valid("bp_first_done");
        n0 = start_cnt;
        held = out_result;
        repeat (8) @(negedge clk);
        check("bp_no_second_start", start_cnt - n0, 32'd0);
        check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
        check("bp_result_held", {16'd0, out_result}, {16'd0, held});
        check("bp_level", {29'd0, level}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_level_pre_accept", {29'd0, level}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_issue_on_accept", {29'd0, level}, 32'd0);
        check("bp_busy_on_accept", {31'd0, busy}, 32'd1);
        wait_drain("drain_bp");

        // reset during WAIT_HIGH drops everything
        eng_lat_lo = 10; eng_lat_hi = 10;
        push(16'h0080, 8'h11);
        push(16'h0180, 8'h22);
        n = 0;
        while (dbg_state != 2'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_high", {30'd0, dbg_state}, 32'd3);
        apply_reset();
        n0 = start_cnt;
        repeat (30) @(negedge clk);
        check("midrst_no_start", start_cnt - n0, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_level", {29'd0, level}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_engine_done", {31'd0, eng_busy}, 32'd0);
        @(posedge clk);
        #1;

        // randomized traffic
        eng_lat_lo = 0; eng_lat_hi = 5;
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            drive_cycle($urandom_range(2, 0) == 0, 16'($urandom), 8'($urandom), acc);
        end
        out_ready = 1'b1;
        wait_drain("drain_random");
        check("iss_q_empty", iss_q.size(), 32'd0);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
